// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory,
// and loads the IF/ID register. Handles stalls, branch redirect with flush, and HLT.
//
// state  | meaning
// IDLE   | one cycle after reset so the memory image can load; no fetch
// RUN    | fetching one instruction per cycle
// HALTED | HLT captured; fetch stopped until a branch or reset
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_enable,
  input  logic [15:0]           imem_rdata,
  output logic [15:0]           ifid_instr,
  output logic [ADDR_WIDTH-1:0] ifid_pc_plus2,
  output logic                  ifid_valid,
  output logic                  halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET = {RESET_PC[ADDR_WIDTH-1:1], 1'b0};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_plus2_q, pc_plus2_d;
  logic                  valid_q, valid_d;
  logic                  halted_q, halted_d;

  logic [ADDR_WIDTH-1:0] pc_next_seq;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  is_hlt;

  assign pc_next_seq = pc_q + PC_STEP;
  assign redirect_pc = {branch_target[ADDR_WIDTH-1:1], 1'b0};
  assign is_hlt      = (imem_rdata[15:12] == HALT_OPCODE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        // Branch wins over stall and over an HLT sitting on the read data.
        if (branch_taken) begin
          pc_d    = redirect_pc;
          instr_d = 16'h0000;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d    = imem_rdata;
          pc_plus2_d = pc_next_seq;
          valid_d    = 1'b1;
          if (is_hlt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_next_seq;
          end
        end
      end
      HALTED: begin
        // A branch here means the HLT was on the wrong path.
        if (branch_taken) begin
          pc_d     = redirect_pc;
          instr_d  = 16'h0000;
          valid_d  = 1'b0;
          state_d  = RUN;
          halted_d = 1'b0;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= PC_RESET;
      instr_q    <= 16'h0000;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr     = pc_q;
  assign imem_enable   = (state_q == RUN);
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus2 = pc_plus2_q;
  assign ifid_valid    = valid_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed boot/stall/branch/halt/wrap sequence
// followed by randomized traffic, checked against a cycle-level behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_addr;
  logic        imem_enable;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  logic [15:0] mem [32768];
  assign imem_rdata = mem[imem_addr[15:1]];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_enable(imem_enable),
    .imem_rdata(imem_rdata), .ifid_instr(ifid_instr), .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        en;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic        halted;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: 0 = waiting after reset, 1 = fetching, 2 = stopped on HLT.
  int          m_mode;
  logic [15:0] m_pc, m_instr, m_pp2;
  logic        m_valid, m_halted;

  function automatic obs_t model_obs();
    obs_t o;
    o.addr = m_pc; o.en = (m_mode == 1); o.instr = m_instr;
    o.pp2 = m_pp2; o.valid = m_valid; o.halted = m_halted;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.addr = imem_addr; o.en = imem_enable; o.instr = ifid_instr;
    o.pp2 = ifid_pc_plus2; o.valid = ifid_valid; o.halted = halted;
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 16'h0000; m_instr = 16'h0000;
    m_pp2 = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got addr=%h en=%b instr=%h pp2=%h valid=%b halted=%b, want addr=%h en=%b instr=%h pp2=%h valid=%b halted=%b",
                  name, act.addr, act.en, act.instr, act.pp2, act.valid, act.halted,
                  exp.addr, exp.en, exp.instr, exp.pp2, exp.valid, exp.halted);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, queue the expectation.
  task automatic cycle(input logic s, input logic b, input logic [15:0] t);
    logic [15:0] word;
    stall = s; branch_taken = b; branch_target = t;
    word = mem[m_pc[15:1]];
    @(posedge clk);
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (b) begin
      m_pc = t & 16'hFFFE; m_instr = 16'h0000; m_valid = 1'b0;
      m_mode = 1; m_halted = 1'b0;
    end else if (m_mode == 1 && !s) begin
      m_instr = word; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
      if (word[15:12] == 4'hF) begin
        m_mode = 2; m_halted = 1'b1;
      end else begin
        m_pc = m_pc + 16'd2;
      end
    end else if (m_mode == 2 && !s) begin
      m_valid = 1'b0;
    end
    exp_q.push_back(model_obs());
    #2;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", dut_obs(), exp_q.pop_front());
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:12] == 4'hF && ($urandom % 3 != 0)) mem[i][15:12] = 4'h7;
    end
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF777;
    mem[4] = 16'hF000; mem[8] = 16'h0808; mem[9] = 16'h0A0A;
    mem[16'h20] = 16'h4040; mem[16'h21] = 16'h4242; mem[16'h7FFF] = 16'hEEEE;

    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", dut_obs(), model_obs());
    rst = 1'b0;
    #1;
    check("idle_no_fetch", dut_obs(), model_obs());

    cycle(0, 0, 16'h0);            // IDLE -> RUN
    cycle(0, 0, 16'h0);            // 1111, pp2=2
    cycle(0, 0, 16'h0);            // 2222, pp2=4
    cycle(1, 0, 16'h0);            // stall at PC=4
    cycle(1, 0, 16'h0);
    cycle(0, 0, 16'h0);            // 3333
    cycle(1, 1, 16'h0041);         // branch beats stall and the HLT at 6
    cycle(0, 0, 16'h0);            // 4040
    cycle(0, 0, 16'h0);            // 4242
    cycle(0, 1, 16'h0008);
    cycle(0, 0, 16'h0);            // F000 captured, halt
    cycle(0, 0, 16'h0);            // valid drops
    cycle(1, 0, 16'h0);
    cycle(0, 0, 16'h0);
    cycle(0, 1, 16'h0010);         // wrong-path halt
    cycle(0, 0, 16'h0);            // 0808
    cycle(0, 0, 16'h0);
    cycle(0, 1, 16'hFFFF);         // wrap test
    cycle(0, 0, 16'h0);            // EEEE, pp2=0, PC=0
    cycle(0, 0, 16'h0);            // 1111 again

    for (int n = 0; n < 400; n++) begin
      logic s, b;
      s = ($urandom % 4 == 0);
      b = ($urandom % 10 == 0);
      cycle(s, b, 16'($urandom));
    end

    // Async reset landing between clock edges.
    cycle(0, 1, 16'h0004);
    cycle(0, 0, 16'h0);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset", dut_obs(), model_obs());
    @(posedge clk);
    #2;
    rst = 1'b0;
    cycle(0, 0, 16'h0);
    cycle(0, 0, 16'h0);
    cycle(0, 0, 16'h0);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the single-cycle/pipelined CPU.
- Owns the program counter and drives the address/enable of the 16-bit byte-addressed instruction memory. That memory reads combinationally, and address bit 0 must be 0.
- Captures the returned instruction into the IF/ID register for decode.
- Handles stall, branch redirect with flush, and HLT detection.

Parameters:
- ADDR_WIDTH, 16, width of PC and instruction-memory address.
- RESET_PC, 16'h0000, PC value loaded on reset (bit 0 must be 0).
- HALT_OPCODE, 4'hF, value of instr[15:12] that marks HLT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall from decode; freezes PC and IF/ID.
- branch_taken  in  1  redirect request from branch resolution.
- branch_target  in  ADDR_WIDTH  redirect address.
- imem_addr  out  ADDR_WIDTH  instruction-memory address (= PC).
- imem_enable  out  1  instruction-memory read enable.
- imem_rdata  in  16  instruction returned combinationally by memory.
- ifid_instr  out  16  registered instruction to decode.
- ifid_pc_plus2  out  ADDR_WIDTH  registered PC+2 of that instruction.
- ifid_valid  out  1  ifid_instr is a real instruction.
- halted  out  1  fetch has stopped on HLT.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, PC=RESET_PC, ifid_instr=16'h0000, ifid_pc_plus2=0, ifid_valid=0, halted=0.
- imem_addr = PC (combinational). imem_enable = 1 only in RUN, else 0.
- FSM states: IDLE, RUN, HALTED.
  - IDLE: lasts exactly one cycle after rst deasserts, so memory image load completes. No fetch; IF/ID held at reset values. Next state is RUN.
  - RUN, priority order per cycle:
    1. branch_taken: PC <= {branch_target[ADDR_WIDTH-1:1],1'b0}. Flush: ifid_valid<=0, ifid_instr<=0. Stay in RUN. Branch overrides stall and any HLT in imem_rdata.
    2. stall: PC, ifid_* all held. No HLT detection.
    3. imem_rdata[15:12]==HALT_OPCODE: IF/ID loads the HLT (valid=1, pc_plus2=PC+2). PC held. Next state HALTED.
    4. Otherwise: ifid_instr<=imem_rdata, ifid_pc_plus2<=PC+2, ifid_valid<=1, PC<=PC+2.
  - HALTED: halted=1 (registered from state). imem_enable=0. PC held.
    - First HALTED cycle onward: if not stall, ifid_valid<=0 (HLT presented to decode exactly once unless stalled). If stall, IF/ID is held.
    - branch_taken in HALTED means the HLT was wrong-path: redirect exactly as in RUN, flush, return to RUN, halted<=0 next cycle.
    - Leaves HALTED only via branch_taken or rst.
- Arithmetic: PC+2 is ADDR_WIDTH-bit modulo; 16'hFFFE+2 wraps to 16'h0000 with no flag.
- PC bit 0 is always 0 (RESET_PC and branch target forced even).
- Latency: instruction at address A appears on ifid_instr the cycle after PC==A with no stall.
- Throughput: one instruction per cycle in RUN.

Test Plan:
- Reset/boot: assert rst, release; memory holds 0x1111@0, 0x2222@2, 0x3333@4 -> IDLE for 1 cycle (imem_enable=0, ifid_valid=0). Then ifid_instr = 1111, 2222, 3333 on consecutive cycles with ifid_pc_plus2 = 2, 4, 6.
- Stall: stall=1 for 2 cycles while PC=4 -> imem_addr stays 4, ifid_instr stays 2222 valid. After release, 3333 appears next cycle.
- Branch + stall together: branch_taken=1, stall=1, branch_target=16'h0041 at PC=6 -> next PC=16'h0040, ifid_valid=0. Next cycle ifid_instr=mem[0x40].
- Halt: mem@8=16'hF000 -> ifid_instr=F000 valid for one cycle, halted=1 from next cycle, imem_enable=0, PC=8 held indefinitely.
- Wrong-path halt: in HALTED assert branch_taken, target 16'h0010 -> halted=0 next cycle, fetch resumes at 0x10.
- Wrap and async reset: PC=16'hFFFE, fetch -> PC=0. Assert rst mid-cycle -> outputs return to reset values immediately, without waiting for clk.
